if_id_reg: RTL and testbench

- Pipeline register between the Instruction Fetch (IF) and Instruction Decode (ID) stages of the toy 5-stage CPU.
- Captures the fetched PC and instruction word on each rising clock edge and presents them to ID for one cycle.
- Supports stall (hold) and flush (insert bubble) control from the hazard/branch logic.

---
 rtl/cpu_defs_pkg.sv | 10 +
 rtl/pipe_reg.sv | 26 ++
 rtl/if_id_reg.sv | 62 ++++++
 tb/tb_if_id_reg.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the pipeline registers of the toy 5-stage CPU.
package cpu_defs_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [INST_BUS-1:0]      NOP_INST = '0;
  localparam logic [INST_ADDR_BUS-1:0] ZERO_PC  = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline field register with async active-low reset, an enable and a
// synchronous clear that loads the same value as reset.
module pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // clr wins over en so a bubble can be inserted while the stage is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched PC and instruction, supports
// stall (hold) and flush (bubble), flush having priority.
module if_id_reg #(
  parameter int                    ADDR_WIDTH = cpu_defs_pkg::INST_ADDR_BUS,
  parameter int                    INST_WIDTH = cpu_defs_pkg::INST_BUS,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(cpu_defs_pkg::NOP_INST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ifPC,
  input  logic [INST_WIDTH-1:0] ifInst,
  input  logic                  stall,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] idPC,
  output logic [INST_WIDTH-1:0] idInst,
  output logic                  idValid
);

  import cpu_defs_pkg::*;

  logic load_en;

  // A held stage ignores ifPC/ifInst entirely, so X on them cannot leak in
  assign load_en = ~stall;

  pipe_reg #(
    .WIDTH   (ADDR_WIDTH),
    .RST_VAL (ADDR_WIDTH'(ZERO_PC))
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (ifPC),
    .q   (idPC)
  );

  pipe_reg #(
    .WIDTH   (INST_WIDTH),
    .RST_VAL (NOP_INST)
  ) u_inst_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (ifInst),
    .q   (idInst)
  );

  pipe_reg #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_valid_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (1'b1),
    .q   (idValid)
  );

endmodule

// File: tb/tb_if_id_reg.sv
// Directed, table-driven bench for if_id_reg plus hand sequences for reset.
module tb_if_id_reg;

  logic        clk;
  logic        rst;
  logic [31:0] ifPC;
  logic [31:0] ifInst;
  logic        stall;
  logic        flush;
  logic [31:0] idPC;
  logic [31:0] idInst;
  logic        idValid;

  int pass_cnt = 0;
  int total_cnt = 0;

  if_id_reg dut (
    .clk     (clk),
    .rst     (rst),
    .ifPC    (ifPC),
    .ifInst  (ifInst),
    .stall   (stall),
    .flush   (flush),
    .idPC    (idPC),
    .idInst  (idInst),
    .idValid (idValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_valid;
  } vec_t;

  localparam int NVEC = 14;
  localparam int NPRE = 9;  // vectors applied before the mid-run reset
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %h, required %h", name, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic valid);
    check({tag, ".idPC"}, idPC, pc);
    check({tag, ".idInst"}, idInst, inst);
    check({tag, ".idValid"}, {31'd0, idValid}, {31'd0, valid});
    $display("[%0t] %s: idPC=%h idInst=%h idValid=%b", $time, tag, idPC, idInst, idValid);
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    stall  = vecs[i].stall;
    flush  = vecs[i].flush;
    ifPC   = vecs[i].pc;
    ifInst = vecs[i].inst;
    @(posedge clk);
    #1;
    check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_inst, vecs[i].exp_valid);
  endtask

  initial begin
    //          stall flush pc      inst           exp_pc  exp_inst       exp_valid
    vecs[0]  = '{1'b1, 1'b0, 32'd19, 32'h1234_5678, 32'd15, 32'hAAAA_2AAA, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 32'd19, 32'h1234_5678, 32'd15, 32'hAAAA_2AAA, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'd19, 32'h1234_5678, 32'd15, 32'hAAAA_2AAA, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 'x,     'x,            32'd15, 32'hAAAA_2AAA, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'd19, 32'h1234_5678, 32'd19, 32'h1234_5678, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'd55, 32'hDEAD_BEEF, 32'd0,  32'h0,         1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'd77, 32'hCAFE_F00D, 32'd0,  32'h0,         1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'd19, 32'h1234_5678, 32'd19, 32'h1234_5678, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'd23, 32'h0,         32'd19, 32'h1234_5678, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,  32'h0000_0013, 32'd0,  32'h0000_0013, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'd4,  32'h0010_0093, 32'd4,  32'h0010_0093, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'd8,  32'h0020_0113, 32'd8,  32'h0020_0113, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'd12, 32'h0030_0193, 32'd12, 32'h0030_0193, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};

    rst    = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    ifPC   = 32'd15;
    ifInst = 32'hAAAA_2AAA;

    // Reset held across clock edges keeps the bubble
    #3;
    check_all("reset_t3", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_edge1", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_all("reset_edge2", 32'd0, 32'd0, 1'b0);

    // Release between edges: nothing captured until the next rising edge
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_all("pre_capture", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_all("capture", 32'd15, 32'hAAAA_2AAA, 1'b1);

    for (int i = 0; i < NPRE; i++) run_vec(i);

    // Async reset between edges while 19/12345678 is held
    #2;
    rst = 1'b0;
    #1;
    check_all("async_reset", 32'd0, 32'd0, 1'b0);
    stall = 1'b0;
    @(posedge clk); #1;
    check_all("async_reset_edge", 32'd0, 32'd0, 1'b0);
    #2;
    rst = 1'b1;

    for (int i = NPRE; i < NVEC; i++) run_vec(i);

    // Inputs changed mid-cycle must not reach the outputs before the edge
    @(negedge clk);
    ifPC   = 32'd100;
    ifInst = 32'h0BAD_F00D;
    #2;
    check_all("mid_cycle_hold", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    check_all("mid_cycle_capture", 32'd100, 32'h0BAD_F00D, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
